wb_multi: RTL

Parametrised writeback stage: accepts a retire bundle of `LANES` instructions per cycle from the memory stage, registers it, resolves intra-bundle exception priority and register write conflicts, then drives regfile, CSR and exception outputs one cycle later. A three-state controller adds a one-cycle flush bubble after an exception and a terminal halt on breakpoint. The stage also keeps a retired-instruction counter. It sits between the memory stage and the regfile/CSR unit and replaces the single-lane pass-through writeback.

---
 rtl/wb_multi.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/wb_multi.sv
// Multi-lane writeback stage: resolves per-bundle exception priority and regfile write conflicts.
// Optional WB_TRAP_DISPLAY_EN prints the trap verdict and ends simulation on breakpoint halt.
module wb_multi #(
   parameter int unsigned XLEN  = 64,
   parameter int unsigned LANES = 2,
   parameter int unsigned CNT_W = 64
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [LANES-1:0]      lane_valid_i,
   input  logic [LANES-1:0]      wen_i,
   input  logic [5*LANES-1:0]    rd_i,
   input  logic [XLEN*LANES-1:0] wdata_i,
   input  logic [XLEN*LANES-1:0] pc_i,
   input  logic [LANES-1:0]      exception_i,
   input  logic [XLEN*LANES-1:0] mcause_i,
   input  logic                  csr_wen_i,
   input  logic [11:0]           csr_addr_i,
   input  logic [XLEN-1:0]       csr_wdata_i,
   input  logic [XLEN-1:0]       a0_i,
   output logic [LANES-1:0]      wen_o,
   output logic [5*LANES-1:0]    rd_o,
   output logic [XLEN*LANES-1:0] wdata_o,
   output logic                  csr_wen_o,
   output logic [11:0]           csr_addr_o,
   output logic [XLEN-1:0]       csr_wdata_o,
   output logic                  exception_o,
   output logic [XLEN-1:0]       mcause_o,
   output logic [XLEN-1:0]       epc_o,
   output logic [CNT_W-1:0]      retired_o,
   output logic                  halt_o,
   output logic [XLEN-1:0]       exit_code_o
);

   localparam logic [XLEN-1:0] Breakpoint = XLEN'(3);

   typedef enum logic [1:0] {StRun, StFlush, StHalt} state_e;

   state_e                state_q, state_d;
   logic [LANES-1:0]      wen_q, wen_d;
   logic [5*LANES-1:0]    rd_q, rd_d;
   logic [XLEN*LANES-1:0] wdata_q, wdata_d;
   logic                  csr_wen_q, csr_wen_d;
   logic [11:0]           csr_addr_q, csr_addr_d;
   logic [XLEN-1:0]       csr_wdata_q, csr_wdata_d;
   logic                  exc_q, exc_d;
   logic [XLEN-1:0]       mcause_q, mcause_d;
   logic [XLEN-1:0]       epc_q, epc_d;
   logic [CNT_W-1:0]      retired_q, retired_d;
   logic                  halt_q, halt_d;
   logic [XLEN-1:0]       exit_q, exit_d;

   logic                  accept;
   logic [LANES-1:0]      commit;
   logic [LANES-1:0]      wen_calc;
   logic                  exc_any;
   logic [XLEN-1:0]       win_cause;
   logic [XLEN-1:0]       win_pc;
   logic [CNT_W-1:0]      n_commit;

   assign in_ready = (state_q == StRun);
   assign accept   = in_valid & in_ready;

   // Oldest excepting valid lane wins; only older valid lanes commit.
   always_comb begin
      commit    = '0;
      exc_any   = 1'b0;
      win_cause = '0;
      win_pc    = '0;
      for (int unsigned k = 0; k < LANES; k++) begin
         if (lane_valid_i[k] && !exc_any) begin
            if (exception_i[k]) begin
               exc_any   = 1'b1;
               win_cause = mcause_i[k*XLEN +: XLEN];
               win_pc    = pc_i[k*XLEN +: XLEN];
            end else begin
               commit[k] = 1'b1;
            end
         end
      end
   end

   // Younger committed writer to the same rd suppresses the older one.
   always_comb begin
      wen_calc = '0;
      n_commit = '0;
      for (int unsigned k = 0; k < LANES; k++) begin
         n_commit    = n_commit + CNT_W'(commit[k]);
         wen_calc[k] = wen_i[k] & commit[k] & (rd_i[5*k +: 5] != 5'd0);
         for (int unsigned j = k + 1; j < LANES; j++) begin
            if (commit[j] && wen_i[j] && (rd_i[5*j +: 5] == rd_i[5*k +: 5])) begin
               wen_calc[k] = 1'b0;
            end
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      wen_d       = '0;
      rd_d        = rd_q;
      wdata_d     = wdata_q;
      csr_wen_d   = 1'b0;
      csr_addr_d  = csr_addr_q;
      csr_wdata_d = csr_wdata_q;
      exc_d       = 1'b0;
      mcause_d    = mcause_q;
      epc_d       = epc_q;
      retired_d   = retired_q;
      halt_d      = halt_q;
      exit_d      = exit_q;
      case (state_q)
         StRun: begin
            if (accept) begin
               wen_d       = wen_calc;
               rd_d        = rd_i;
               wdata_d     = wdata_i;
               csr_wen_d   = csr_wen_i & commit[0];
               csr_addr_d  = csr_addr_i;
               csr_wdata_d = csr_wdata_i;
               retired_d   = retired_q + n_commit;
               if (exc_any) begin
                  exc_d    = 1'b1;
                  mcause_d = win_cause;
                  epc_d    = win_pc;
                  if (win_cause == Breakpoint) begin
                     state_d = StHalt;
                     halt_d  = 1'b1;
                     exit_d  = a0_i;
                  end else begin
                     state_d = StFlush;
                  end
               end
            end
         end
         StFlush: state_d = StRun;
         StHalt:  state_d = StHalt;
         default: state_d = StRun;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= StRun;
         wen_q       <= '0;
         rd_q        <= '0;
         wdata_q     <= '0;
         csr_wen_q   <= 1'b0;
         csr_addr_q  <= '0;
         csr_wdata_q <= '0;
         exc_q       <= 1'b0;
         mcause_q    <= '0;
         epc_q       <= '0;
         retired_q   <= '0;
         halt_q      <= 1'b0;
         exit_q      <= '0;
      end else begin
         state_q     <= state_d;
         wen_q       <= wen_d;
         rd_q        <= rd_d;
         wdata_q     <= wdata_d;
         csr_wen_q   <= csr_wen_d;
         csr_addr_q  <= csr_addr_d;
         csr_wdata_q <= csr_wdata_d;
         exc_q       <= exc_d;
         mcause_q    <= mcause_d;
         epc_q       <= epc_d;
         retired_q   <= retired_d;
         halt_q      <= halt_d;
         exit_q      <= exit_d;
      end
   end

`ifdef WB_TRAP_DISPLAY_EN
   always_ff @(posedge clock) begin
      if (reset && halt_d && !halt_q) begin
         if (exit_d == '0) begin
            $display("good trap: pc=%h exit=%h", epc_d, exit_d);
         end else begin
            $display("bad trap: pc=%h exit=%h", epc_d, exit_d);
         end
         $finish;
      end
   end
`else
   // Synthesisable build: halt is signalled through halt_o only.
`endif

   assign wen_o       = wen_q;
   assign rd_o        = rd_q;
   assign wdata_o     = wdata_q;
   assign csr_wen_o   = csr_wen_q;
   assign csr_addr_o  = csr_addr_q;
   assign csr_wdata_o = csr_wdata_q;
   assign exception_o = exc_q;
   assign mcause_o    = mcause_q;
   assign epc_o       = epc_q;
   assign retired_o   = retired_q;
   assign halt_o      = halt_q;
   assign exit_code_o = exit_q;

endmodule
